lsu_addr_stage: RTL and testbench

- Upstream neighbour of the PMP data check.
- Accepts LSU load/store requests (virtual address, size, store flag, privilege) and performs the misalignment check.
- Forms the bare-mode physical address (no translation) and registers everything through a 2-entry skid buffer.
- Presents one request per cycle to the PMP data stage, with lsu_valid/paddr/vaddr/exception/is_store/privilege already aligned.

---
 rtl/lsu_addr_pkg.sv | 46 ++++
 rtl/lsu_skid_buf.sv | 71 +++++++
 rtl/lsu_addr_stage.sv | 90 +++++++++
 tb/tb_lsu_addr_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_addr_pkg.sv
// Shared types and constants for the LSU address stage: access sizes, exception
// causes and the registered request entry handed to the PMP data stage.
package lsu_addr_pkg;

    localparam int unsigned LSU_VLEN          = 64;
    localparam int unsigned LSU_PLEN          = 56;
    localparam int unsigned LSU_XLEN          = 64;
    localparam int unsigned LSU_TRANS_ID_BITS = 3;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } lsu_size_e;

    localparam logic [LSU_XLEN-1:0] CAUSE_LD_ADDR_MISALIGNED = LSU_XLEN'(4);
    localparam logic [LSU_XLEN-1:0] CAUSE_LD_ACCESS_FAULT    = LSU_XLEN'(5);
    localparam logic [LSU_XLEN-1:0] CAUSE_ST_ADDR_MISALIGNED = LSU_XLEN'(6);
    localparam logic [LSU_XLEN-1:0] CAUSE_ST_ACCESS_FAULT    = LSU_XLEN'(7);

    typedef struct packed {
        logic [LSU_PLEN-1:0]          paddr;
        logic [LSU_VLEN-1:0]          vaddr;
        logic                         is_store;
        logic                         ex_valid;
        logic [LSU_XLEN-1:0]          ex_cause;
        logic [LSU_XLEN-1:0]          ex_tval;
        logic [1:0]                   priv_lvl;
        logic                         v;
        logic [LSU_TRANS_ID_BITS-1:0] trans_id;
    } lsu_addr_entry_t;

    // Natural alignment: the low log2(size) address bits must be zero.
    function automatic logic is_misaligned(lsu_size_e size, logic [2:0] addr_lo);
        logic mis;
        case (size)
            SIZE_HALF:  mis = addr_lo[0];
            SIZE_WORD:  mis = |addr_lo[1:0];
            SIZE_DWORD: mis = |addr_lo;
            default:    mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; ready toward the producer depends only
// on registered state, so there is no combinational path from out_ready.
module lsu_skid_buf #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic srst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic main_valid_reg, main_valid_next;
    logic skid_valid_reg, skid_valid_next;
    T     main_data_reg, main_data_next;
    T     skid_data_reg, skid_data_next;
    logic accept;
    logic drain;

    always_comb begin
        accept          = in_valid && !skid_valid_reg && !flush;
        drain           = main_valid_reg && out_ready;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        main_data_next  = main_data_reg;
        skid_data_next  = skid_data_reg;

        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!main_valid_reg || drain) begin
            // Main is free this cycle: refill from skid first to keep order.
            if (skid_valid_reg) begin
                main_valid_next = 1'b1;
                main_data_next  = skid_data_reg;
                skid_valid_next = 1'b0;
            end else begin
                main_valid_next = accept;
                if (accept) begin
                    main_data_next = in_data;
                end
            end
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_data_next  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_data_reg  <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            main_data_reg  <= main_data_next;
            skid_data_reg  <= skid_data_next;
        end
    end

    assign in_ready  = !skid_valid_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;

endmodule

// File: rtl/lsu_addr_stage.sv
// LSU address stage: misalignment check, bare-mode physical address, skid-buffered
// hand-off to the PMP data stage. Define ADDR_RANGE_CHECK_EN to fault on vaddr bits above PLEN.
module lsu_addr_stage
    import lsu_addr_pkg::*;
#(
    parameter int unsigned VLEN          = LSU_VLEN,
    parameter int unsigned PLEN          = LSU_PLEN,
    parameter int unsigned XLEN          = LSU_XLEN,
    parameter int unsigned TRANS_ID_BITS = LSU_TRANS_ID_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [VLEN-1:0]          req_vaddr_i,
    input  logic [1:0]               req_size_i,
    input  logic                     req_is_store_i,
    input  logic [1:0]               req_priv_lvl_i,
    input  logic                     req_v_i,
    input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,
    output logic                     lsu_valid_o,
    input  logic                     lsu_ready_i,
    output logic [PLEN-1:0]          lsu_paddr_o,
    output logic [VLEN-1:0]          lsu_vaddr_o,
    output logic                     lsu_is_store_o,
    output logic                     lsu_ex_valid_o,
    output logic [XLEN-1:0]          lsu_ex_cause_o,
    output logic [XLEN-1:0]          lsu_ex_tval_o,
    output logic [1:0]               ld_st_priv_lvl_o,
    output logic                     ld_st_v_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o
);

    lsu_addr_entry_t req_entry;
    lsu_addr_entry_t out_entry;
    logic            misaligned;
    logic            range_fault;

    always_comb begin
        misaligned = is_misaligned(lsu_size_e'(req_size_i), req_vaddr_i[2:0]);
`ifdef ADDR_RANGE_CHECK_EN
        range_fault = |req_vaddr_i[VLEN-1:PLEN];
`else
        range_fault = 1'b0;
`endif
        req_entry          = '0;
        req_entry.paddr    = req_vaddr_i[PLEN-1:0];
        req_entry.vaddr    = req_vaddr_i;
        req_entry.is_store = req_is_store_i;
        req_entry.priv_lvl = req_priv_lvl_i;
        req_entry.v        = req_v_i;
        req_entry.trans_id = req_trans_id_i;
        // Faulting requests still travel downstream so they retire as exceptions.
        if (misaligned) begin
            req_entry.ex_valid = 1'b1;
            req_entry.ex_cause = req_is_store_i ? CAUSE_ST_ADDR_MISALIGNED : CAUSE_LD_ADDR_MISALIGNED;
            req_entry.ex_tval  = XLEN'(req_vaddr_i);
        end else if (range_fault) begin
            req_entry.ex_valid = 1'b1;
            req_entry.ex_cause = req_is_store_i ? CAUSE_ST_ACCESS_FAULT : CAUSE_LD_ACCESS_FAULT;
            req_entry.ex_tval  = XLEN'(req_vaddr_i);
        end
    end

    lsu_skid_buf #(
        .T(lsu_addr_entry_t)
    ) u_skid_buf (
        .clk      (clk_i),
        .srst     (rst_i),
        .flush    (flush_i),
        .in_valid (req_valid_i),
        .in_ready (req_ready_o),
        .in_data  (req_entry),
        .out_valid(lsu_valid_o),
        .out_ready(lsu_ready_i),
        .out_data (out_entry)
    );

    assign lsu_paddr_o      = out_entry.paddr;
    assign lsu_vaddr_o      = out_entry.vaddr;
    assign lsu_is_store_o   = out_entry.is_store;
    assign lsu_ex_valid_o   = out_entry.ex_valid;
    assign lsu_ex_cause_o   = out_entry.ex_cause;
    assign lsu_ex_tval_o    = out_entry.ex_tval;
    assign ld_st_priv_lvl_o = out_entry.priv_lvl;
    assign ld_st_v_o        = out_entry.v;
    assign trans_id_o       = out_entry.trans_id;

endmodule

// File: tb/tb_lsu_addr_stage.sv
// Bench for lsu_addr_stage: queue-based model of the buffered request stream,
// checked every cycle, plus directed vectors with hand-computed literals.
module tb_lsu_addr_stage;

    localparam int VLEN = 64;
    localparam int PLEN = 56;
    localparam int XLEN = 64;
    localparam int TIDW = 3;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            flush_i = 1'b0;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [VLEN-1:0] req_vaddr_i = '0;
    logic [1:0]      req_size_i = '0;
    logic            req_is_store_i = 1'b0;
    logic [1:0]      req_priv_lvl_i = '0;
    logic            req_v_i = 1'b0;
    logic [TIDW-1:0] req_trans_id_i = '0;
    logic            lsu_valid_o;
    logic            lsu_ready_i = 1'b0;
    logic [PLEN-1:0] lsu_paddr_o;
    logic [VLEN-1:0] lsu_vaddr_o;
    logic            lsu_is_store_o;
    logic            lsu_ex_valid_o;
    logic [XLEN-1:0] lsu_ex_cause_o;
    logic [XLEN-1:0] lsu_ex_tval_o;
    logic [1:0]      ld_st_priv_lvl_o;
    logic            ld_st_v_o;
    logic [TIDW-1:0] trans_id_o;

    always #5 clk = ~clk;

    lsu_addr_stage dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_vaddr_i     (req_vaddr_i),
        .req_size_i      (req_size_i),
        .req_is_store_i  (req_is_store_i),
        .req_priv_lvl_i  (req_priv_lvl_i),
        .req_v_i         (req_v_i),
        .req_trans_id_i  (req_trans_id_i),
        .lsu_valid_o     (lsu_valid_o),
        .lsu_ready_i     (lsu_ready_i),
        .lsu_paddr_o     (lsu_paddr_o),
        .lsu_vaddr_o     (lsu_vaddr_o),
        .lsu_is_store_o  (lsu_is_store_o),
        .lsu_ex_valid_o  (lsu_ex_valid_o),
        .lsu_ex_cause_o  (lsu_ex_cause_o),
        .lsu_ex_tval_o   (lsu_ex_tval_o),
        .ld_st_priv_lvl_o(ld_st_priv_lvl_o),
        .ld_st_v_o       (ld_st_v_o),
        .trans_id_o      (trans_id_o)
    );

    typedef struct {
        logic [63:0] paddr;
        logic [63:0] vaddr;
        logic        is_store;
        logic        ex_valid;
        logic [63:0] cause;
        logic [63:0] tval;
        logic [1:0]  priv;
        logic        v;
        logic [2:0]  id;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   model_live = 0;
    bit   rst_seen = 0;
    bit   last_accept = 0;

    function automatic exp_t predict(logic [63:0] va, logic [1:0] size, logic st,
                                     logic [1:0] pr, logic v, logic [2:0] id);
        exp_t        e;
        logic [63:0] bytes;
        bit          mis;
        bit          oor;
        bytes = 64'd1 << size;
        mis   = (va % bytes) != 64'd0;
        oor   = 1'b0;
`ifdef ADDR_RANGE_CHECK_EN
        oor = (va >> PLEN) != 64'd0;
`endif
        e.paddr    = va & ((64'd1 << PLEN) - 64'd1);
        e.vaddr    = va;
        e.is_store = st;
        e.priv     = pr;
        e.v        = v;
        e.id       = id;
        e.ex_valid = mis || oor;
        e.cause    = mis ? (st ? 64'd6 : 64'd4) : oor ? (st ? 64'd7 : 64'd5) : 64'd0;
        e.tval     = (mis || oor) ? va : 64'd0;
        return e;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
        end
    endtask

    // Model: a FIFO of at most two pending requests.
    always @(posedge clk) begin : model
        bit acc;
        last_accept = 0;
        if (rst_i) begin
            q.delete();
            model_live = 1;
            rst_seen   = 1;
        end else if (flush_i) begin
            q.delete();
            rst_seen = 0;
        end else begin
            rst_seen = 0;
            acc = req_valid_i && (q.size() < 2);
            if (q.size() > 0 && lsu_ready_i) void'(q.pop_front());
            if (acc) begin
                q.push_back(predict(req_vaddr_i, req_size_i, req_is_store_i,
                                    req_priv_lvl_i, req_v_i, req_trans_id_i));
                last_accept = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("req_ready", 64'(req_ready_o), 64'(q.size() < 2));
            check("lsu_valid", 64'(lsu_valid_o), 64'(q.size() > 0));
            if (q.size() > 0) begin
                check("paddr", 64'(lsu_paddr_o), q[0].paddr);
                check("vaddr", lsu_vaddr_o, q[0].vaddr);
                check("is_store", 64'(lsu_is_store_o), 64'(q[0].is_store));
                check("ex_valid", 64'(lsu_ex_valid_o), 64'(q[0].ex_valid));
                check("ex_cause", lsu_ex_cause_o, q[0].cause);
                check("ex_tval", lsu_ex_tval_o, q[0].tval);
                check("priv", 64'(ld_st_priv_lvl_o), 64'(q[0].priv));
                check("virt", 64'(ld_st_v_o), 64'(q[0].v));
                check("trans_id", 64'(trans_id_o), 64'(q[0].id));
            end
            if (rst_seen) begin
                check("rst_paddr", 64'(lsu_paddr_o), 64'd0);
                check("rst_vaddr", lsu_vaddr_o, 64'd0);
                check("rst_cause", lsu_ex_cause_o, 64'd0);
                check("rst_tval", lsu_ex_tval_o, 64'd0);
                check("rst_misc", {57'd0, lsu_is_store_o, lsu_ex_valid_o, ld_st_priv_lvl_o,
                                   ld_st_v_o, trans_id_o[1:0]} | 64'(trans_id_o), 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(logic [63:0] va, logic [1:0] size, logic st,
                         logic [1:0] pr, logic v, logic [2:0] id);
        req_valid_i    = 1'b1;
        req_vaddr_i    = va;
        req_size_i     = size;
        req_is_store_i = st;
        req_priv_lvl_i = pr;
        req_v_i        = v;
        req_trans_id_i = id;
    endtask

    initial begin
        #100000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: got timeout want finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        step();
        step();
        rst_i = 1'b0;
        check("lit_reset_ready", 64'(req_ready_o), 64'd1);
        check("lit_reset_valid", 64'(lsu_valid_o), 64'd0);

        // Back-to-back traffic with the consumer always ready.
        lsu_ready_i = 1'b1;
        drive(64'h8000_0003, 2'd0, 1'b0, 2'd3, 1'b0, 3'd1);
        step();
        check("lit_t1_valid", 64'(lsu_valid_o), 64'd1);
        check("lit_t1_paddr", 64'(lsu_paddr_o), 64'h8000_0003);
        check("lit_t1_ex", 64'(lsu_ex_valid_o), 64'd0);
        drive(64'h8000_0002, 2'd2, 1'b1, 2'd1, 1'b1, 3'd2);
        step();
        check("lit_t2_ex", 64'(lsu_ex_valid_o), 64'd1);
        check("lit_t2_cause", lsu_ex_cause_o, 64'd6);
        check("lit_t2_tval", lsu_ex_tval_o, 64'h8000_0002);
        check("lit_t2_store", 64'(lsu_is_store_o), 64'd1);
        drive(64'h8000_1001, 2'd1, 1'b0, 2'd0, 1'b0, 3'd3);
        step();
        check("lit_half_ld_cause", lsu_ex_cause_o, 64'd4);
        drive(64'h8000_1004, 2'd3, 1'b1, 2'd3, 1'b0, 3'd4);
        step();
        check("lit_dw_st_cause", lsu_ex_cause_o, 64'd6);
        drive(64'h8000_1008, 2'd3, 1'b0, 2'd3, 1'b0, 3'd5);
        step();
        check("lit_dw_aligned_ex", 64'(lsu_ex_valid_o), 64'd0);
        drive(64'h8000_1006, 2'd1, 1'b1, 2'd2, 1'b1, 3'd6);
        step();
        check("lit_half_st_ex", 64'(lsu_ex_valid_o), 64'd0);
        drive(64'h0100_0000_0000_0000, 2'd3, 1'b0, 2'd1, 1'b0, 3'd7);
        step();
`ifdef ADDR_RANGE_CHECK_EN
        check("lit_range_cause", lsu_ex_cause_o, 64'd5);
        check("lit_range_tval", lsu_ex_tval_o, 64'h0100_0000_0000_0000);
`else
        check("lit_range_ex", 64'(lsu_ex_valid_o), 64'd0);
        check("lit_range_paddr", 64'(lsu_paddr_o), 64'd0);
`endif
        drive(64'hFF00_0000_0000_0001, 2'd1, 1'b1, 2'd0, 1'b0, 3'd0);
        step();
        check("lit_mis_priority", lsu_ex_cause_o, 64'd6);
        req_valid_i = 1'b0;
        step();

        // Stall: A and B fill the buffer, C is held off until space frees.
        lsu_ready_i = 1'b0;
        drive(64'h0000_0100, 2'd2, 1'b0, 2'd3, 1'b0, 3'd1);
        step();
        check("lit_stall_a", 64'(trans_id_o), 64'd1);
        drive(64'h0000_0204, 2'd2, 1'b1, 2'd3, 1'b0, 3'd2);
        step();
        check("lit_stall_ready", 64'(req_ready_o), 64'd0);
        drive(64'h0000_0308, 2'd3, 1'b0, 2'd3, 1'b0, 3'd3);
        step();
        check("lit_stall_hold_a", 64'(trans_id_o), 64'd1);
        step();
        lsu_ready_i = 1'b1;
        step();
        check("lit_drain_b", 64'(trans_id_o), 64'd2);
        check("lit_c_not_yet", 64'(last_accept), 64'd0);
        step();
        check("lit_c_accepted", 64'(last_accept), 64'd1);
        check("lit_drain_c", 64'(trans_id_o), 64'd3);
        req_valid_i = 1'b0;
        step();
        check("lit_empty", 64'(lsu_valid_o), 64'd0);

        // Flush a full buffer while a new request is presented.
        lsu_ready_i = 1'b0;
        drive(64'h0000_0400, 2'd0, 1'b0, 2'd0, 1'b0, 3'd4);
        step();
        drive(64'h0000_0500, 2'd0, 1'b1, 2'd0, 1'b0, 3'd5);
        step();
        flush_i = 1'b1;
        drive(64'h0000_0600, 2'd0, 1'b0, 2'd0, 1'b0, 3'd6);
        step();
        check("lit_flush_valid", 64'(lsu_valid_o), 64'd0);
        check("lit_flush_ready", 64'(req_ready_o), 64'd1);
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        lsu_ready_i = 1'b1;
        step();
        step();
        check("lit_flush_dropped", 64'(lsu_valid_o), 64'd0);

        // Reset while a stalled request is being presented.
        lsu_ready_i = 1'b0;
        drive(64'h8000_0002, 2'd2, 1'b1, 2'd2, 1'b1, 3'd7);
        step();
        check("lit_prerst_valid", 64'(lsu_valid_o), 64'd1);
        req_valid_i = 1'b0;
        rst_i       = 1'b1;
        step();
        rst_i = 1'b0;
        check("lit_rst_valid", 64'(lsu_valid_o), 64'd0);
        check("lit_rst_ready", 64'(req_ready_o), 64'd1);
        check("lit_rst_cause", lsu_ex_cause_o, 64'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
